// File: rtl/riscv_test_pkg.sv
// riscv_test_pkg: register indices, magic values and FSM state codes for riscv_test_monitor
package riscv_test_pkg;
    localparam logic [4:0] REG_TESTNUM = 5'd3;
    localparam logic [4:0] REG_DONE    = 5'd26;
    localparam logic [4:0] REG_RESULT  = 5'd27;
    localparam int DONE_MAGIC = 1;
    localparam int PASS_MAGIC = 1;
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;
endpackage

// File: rtl/test_mon_sat_counter.sv
// test_mon_sat_counter: saturating up-counter with sync clear and enable
//   clk   in  clock, rising edge
//   rst_n in  synchronous active-low reset
//   clr   in  synchronous clear (wins over en)
//   en    in  count enable
//   q     out count value, holds at all-ones
module test_mon_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        q <= (!rst_n || clr) ? '0 : (en && q != '1) ? q + 1'b1 : q;
endmodule

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: riscv-tests pass/fail verdict from snooped register-file write-backs
//   sys_clk, sys_rst_n          clock and synchronous active-low reset
//   wb_en, wb_addr, wb_data     register-file write port of the core
//   test_done/pass/fail         sticky verdict flags
//   fail_testnum                x3 at verdict, 0 on pass
//   run_cycles                  saturating cycles spent in RUN
//   test_timeout                watchdog verdict; only with TEST_MON_TIMEOUT_EN, else 0
module riscv_test_monitor
    import riscv_test_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned XLEN           = 32
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            test_done,
    output logic            test_pass,
    output logic            test_fail,
    output logic [XLEN-1:0] fail_testnum,
    output logic [31:0]     run_cycles,
    output logic            test_timeout
);
    localparam int SW = $clog2(SETTLE_CYCLES) + 1;

    if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("riscv_test_monitor: SETTLE_CYCLES must be >=1 and TIMEOUT_CYCLES >=2");
    end

    logic [1:0]      state;
    logic [XLEN-1:0] testnum, result, testnum_nx, result_nx;
    logic [SW-1:0]   settle_cnt;
    logic            live, go_settle, settle_end, pass_nx;

    // Verdicts sample the shadows including a write landing on the same edge.
    assign live       = state == ST_RUN || state == ST_SETTLE;
    assign testnum_nx = (wb_en && wb_addr == REG_TESTNUM) ? wb_data : testnum;
    assign result_nx  = (wb_en && wb_addr == REG_RESULT) ? wb_data : result;
    assign go_settle  = state == ST_RUN && wb_en && wb_addr == REG_DONE && wb_data == XLEN'(DONE_MAGIC);
    assign settle_end = state == ST_SETTLE && settle_cnt == SW'(SETTLE_CYCLES - 1);
    assign pass_nx    = result_nx == XLEN'(PASS_MAGIC);

    test_mon_sat_counter #(.W(32)) u_run_cnt (
        .clk(sys_clk), .rst_n(sys_rst_n), .clr(1'b0), .en(state == ST_RUN), .q(run_cycles)
    );

    test_mon_sat_counter #(.W(SW)) u_settle_cnt (
        .clk(sys_clk), .rst_n(sys_rst_n), .clr(go_settle), .en(state == ST_SETTLE), .q(settle_cnt)
    );

`ifndef TEST_MON_TIMEOUT_EN
    assign test_timeout = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state        <= ST_RUN;
            testnum      <= '0;
            result       <= '0;
            test_done    <= 1'b0;
            test_pass    <= 1'b0;
            test_fail    <= 1'b0;
            fail_testnum <= '0;
`ifdef TEST_MON_TIMEOUT_EN
            test_timeout <= 1'b0;
`endif
        end else begin
            if (live) begin
                testnum <= testnum_nx;
                result  <= result_nx;
            end
            if (go_settle) begin
                state <= ST_SETTLE;
            end else if (settle_end) begin
                state        <= ST_DONE;
                test_done    <= 1'b1;
                test_pass    <= pass_nx;
                test_fail    <= !pass_nx;
                fail_testnum <= pass_nx ? '0 : testnum_nx;
`ifdef TEST_MON_TIMEOUT_EN
            end else if (state == ST_RUN && run_cycles >= 32'(TIMEOUT_CYCLES)) begin
                state        <= ST_TIMEOUT;
                test_timeout <= 1'b1;
                test_done    <= 1'b1;
                test_fail    <= 1'b1;
                fail_testnum <= testnum_nx;
`endif
            end
        end
    end
endmodule
